mem_port_arbiter: RTL and testbench

//  Shares the single RV32 memory port between instruction fetch (IF) and the MEM stage.
//  MEM-stage requests come from the EX/MEM latch outputs (addr, writeData, exmem_W).
//  A grant FSM serialises the two requesters onto the port, with a starvation guard
//  for IF and a no-ack timeout. Pending requests hold the IF/MEM latches via stall_if / stall_mem.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM stage,
// with a fetch starvation guard and a no-ack timeout that completes the access with err.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                err,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic [7:0]    timer;
  logic          grant_i, grant_d;
  logic          busy, timed_out, streak_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        // Data wins a tie unless it has already taken its allowed streak past a waiting fetch.
        if (dm_req && !(if_req && streak_full)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: if (mem_ack || timed_out) state_nxt = RESP;
      RESP:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == BUSY_I) || (state == BUSY_D);
    timed_out   = (timer == 8'(TIMEOUT - 1));
    streak_full = (streak == SW'(MAX_D_STREAK));
    stall_if    = if_req & ~if_ack;
    stall_mem   = dm_req & ~dm_ack;
  end

  // Acks are raised on the edge that leaves BUSY, so they are high exactly during RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
      streak    <= '0;
      timer     <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      err    <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_be;
        timer     <= '0;
        if (!if_req)          streak <= '0;
        else if (!streak_full) streak <= streak + 1'b1;
      end else if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= '1;
        timer     <= '0;
        streak    <= '0;
      end else if (busy) begin
        if (mem_ack || timed_out) begin
          mem_req <= 1'b0;
          err     <= ~mem_ack;
          if (state == BUSY_I) begin
            if_ack   <= 1'b1;
            if_rdata <= mem_ack ? mem_rdata : '0;
          end else begin
            dm_ack   <= 1'b1;
            dm_rdata <= mem_ack ? mem_rdata : '0;
          end
        end else begin
          timer <= timer + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int MAX_D = 4;
  localparam int TMO   = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [3:0]  dm_be = '0;
  logic        if_ack, dm_ack, err, stall_if, stall_mem, mem_req, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAX_D), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .err(err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) tick;
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, dm_ack, if_rdata, dm_rdata, err} !== '0) begin
      errors++; $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h be=%h ia=%b da=%b ird=%h drd=%h err=%b want all 0",
        mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, dm_ack, if_rdata, dm_rdata, err); end
    checks++; if ({stall_if, stall_mem} !== 2'b00) begin errors++; $display("FAIL reset_stall got %b want 00", {stall_if, stall_mem}); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_if_read;
    if_req = 1'b1; if_addr = 32'h40;
    tick;
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b0, 32'h40, 32'h0, 4'hF}) begin
      errors++; $display("FAIL if_port got req=%b we=%b addr=%h wd=%h be=%h want 1 0 00000040 00000000 f",
        mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
    checks++; if ({if_ack, stall_if} !== 2'b01) begin errors++; $display("FAIL if_busy_stall got ack,stall=%b want 01", {if_ack, stall_if}); end
    mem_ack = 1'b1; mem_rdata = 32'h13;
    tick;
    checks++; if ({if_ack, dm_ack, err, mem_req, stall_if} !== 5'b10000) begin
      errors++; $display("FAIL if_ack_cycle got ia,da,err,req,stall=%b want 10000", {if_ack, dm_ack, err, mem_req, stall_if}); end
    checks++; if (if_rdata !== 32'h13) begin errors++; $display("FAIL if_rdata got %h want 00000013", if_rdata); end
    if_req = 1'b0; mem_ack = 1'b0;
    tick;
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL if_ack_clear got %b want 0", if_ack); end
  endtask

  task automatic test_dm_write;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF; dm_be = 4'h3;
    tick;
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3}) begin
      errors++; $display("FAIL dm_port got req=%b we=%b addr=%h wd=%h be=%h want 1 1 00000100 deadbeef 3",
        mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
    checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL dm_stall got %b want 1", stall_mem); end
    dm_addr = 32'h999; dm_wdata = 32'h0; mem_rdata = 32'h0;
    tick;
    checks++; if ({mem_req, dm_ack, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL dm_hold got req=%b ack=%b addr=%h wd=%h want 1 0 00000100 deadbeef", mem_req, dm_ack, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    tick;
    checks++; if ({dm_ack, if_ack, err, mem_req} !== 4'b1000) begin
      errors++; $display("FAIL dm_ack_cycle got da,ia,err,req=%b want 1000", {dm_ack, if_ack, err, mem_req}); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL dm_rdata got %h want 00000000", dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    tick;
    checks++; if (dm_ack !== 1'b0) begin errors++; $display("FAIL dm_ack_once got %b want 0", dm_ack); end
  endtask

  // Both requesters held high: data may take MAX_D grants in a row, then fetch gets one.
  task automatic grant_sequence(input int n, input string tag);
    int  run;
    int  w;
    bit  exp_i;
    run = 0;
    for (int g = 0; g < n; g++) begin
      w = 0;
      do begin tick; w++; end while (mem_req !== 1'b1 && w < 4);
      exp_i = (run == MAX_D);
      run   = exp_i ? 0 : run + 1;
      checks++; if (mem_req !== 1'b1 || (mem_addr === 32'h1000) !== exp_i) begin
        errors++; $display("FAIL %s_grant%0d got req=%b addr=%h want fetch=%0b", tag, g, mem_req, mem_addr, exp_i); end
      mem_ack = 1'b1; mem_rdata = $urandom;
      tick;
      mem_ack = 1'b0;
      checks++; if ({if_ack, dm_ack} !== {exp_i, ~exp_i}) begin
        errors++; $display("FAIL %s_ack%0d got ia,da=%b want %b", tag, g, {if_ack, dm_ack}, {exp_i, ~exp_i}); end
      if (g == n - 1) begin if_req = 1'b0; dm_req = 1'b0; end
    end
    tick;
  endtask

  task automatic test_priority;
    if_addr = 32'h1000; dm_addr = 32'h2000; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    grant_sequence(10, "prio");
  endtask

  task automatic test_timeout;
    int n;
    bit bad;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_be = 4'(($urandom));
    tick;
    n = 0; bad = 1'b0;
    while (mem_req === 1'b1 && n < 300) begin
      n++;
      bad |= (if_ack | dm_ack | err);
      tick;
    end
    checks++; if (n !== TMO) begin errors++; $display("FAIL tmo_busy_cycles got %0d want %0d", n, TMO); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL tmo_early_ack got %b want 0", bad); end
    checks++; if ({dm_ack, err, if_ack} !== 3'b110) begin
      errors++; $display("FAIL tmo_ack_err got da,err,ia=%b want 110", {dm_ack, err, if_ack}); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h want 00000000", dm_rdata); end
    dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if ({dm_ack, if_ack, err, mem_req} !== 4'b0000 || dm_rdata !== 32'h0) begin
        errors++; $display("FAIL tmo_late_ack%0d got da,ia,err,req=%b rdata=%h want 0000 00000000",
          i, {dm_ack, if_ack, err, mem_req}, dm_rdata); end
    end
    mem_ack = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    if_addr = 32'h1000; dm_addr = 32'h2000; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    repeat (2) begin
      tick; mem_ack = 1'b1;
      tick; mem_ack = 1'b0;
      tick;
    end
    tick;
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_req, if_ack, dm_ack} !== 3'b000) begin
      errors++; $display("FAIL rstmid_async got req,ia,da=%b want 000", {mem_req, if_ack, dm_ack}); end
    @(negedge clk);
    checks++; if ({mem_req, if_ack, dm_ack, err} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_held got req,ia,da,err=%b want 0000", {mem_req, if_ack, dm_ack, err}); end
    rst = 1'b0;
    grant_sequence(5, "rstmid");
  endtask

  task automatic test_random;
    int          gk, bk, streak_m, bcyc, cyc;
    bit          busy, port_free, free_pending, ack_drv, exp_ia, exp_da;
    logic [31:0] g_addr, g_wdata, r_data;
    logic        g_we;
    logic [3:0]  g_be;
    gk = 0; bk = 0; streak_m = 0; bcyc = 0; cyc = 0;
    busy = 0; port_free = 1; free_pending = 0; ack_drv = 0;
    g_addr = '0; g_wdata = '0; r_data = '0; g_we = 1'b0; g_be = '0;
    while (cyc < 3000) begin
      @(negedge clk); cyc++;
      if (free_pending) begin port_free = 1; free_pending = 0; end
      exp_ia = ack_drv && bk == 1;
      exp_da = ack_drv && bk == 2;
      if (ack_drv) begin busy = 0; free_pending = 1; end
      if (gk != 0) begin busy = 1; bk = gk; bcyc = 0; end

      checks++; if ({if_ack, dm_ack, err} !== {exp_ia, exp_da, 1'b0}) begin
        errors++; $display("FAIL rnd_ack cyc=%0d got ia,da,err=%b want %b", cyc, {if_ack, dm_ack, err}, {exp_ia, exp_da, 1'b0}); end
      if (exp_ia) begin checks++; if (if_rdata !== r_data) begin errors++; $display("FAIL rnd_if_rdata cyc=%0d got %h want %h", cyc, if_rdata, r_data); end end
      if (exp_da) begin checks++; if (dm_rdata !== r_data) begin errors++; $display("FAIL rnd_dm_rdata cyc=%0d got %h want %h", cyc, dm_rdata, r_data); end end
      checks++; if (mem_req !== busy) begin errors++; $display("FAIL rnd_mem_req cyc=%0d got %b want %b", cyc, mem_req, busy); end
      if (busy) begin
        checks++; if ({mem_we, mem_addr, mem_wdata, mem_be} !== {g_we, g_addr, g_wdata, g_be}) begin
          errors++; $display("FAIL rnd_port cyc=%0d got we=%b addr=%h wd=%h be=%h want %b %h %h %h",
            cyc, mem_we, mem_addr, mem_wdata, mem_be, g_we, g_addr, g_wdata, g_be); end
      end
      checks++; if ({stall_if, stall_mem} !== {if_req & ~exp_ia, dm_req & ~exp_da}) begin
        errors++; $display("FAIL rnd_stall cyc=%0d got %b want %b", cyc, {stall_if, stall_mem}, {if_req & ~exp_ia, dm_req & ~exp_da}); end

      // Requesters: drop after ack, otherwise occasionally raise; granted ones may wiggle their inputs.
      gk = 0;
      if (exp_ia) if_req = 1'b0;
      else if (!if_req && cyc < 2800 && $urandom_range(2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
      else if (if_req && busy && bk == 1 && $urandom_range(3) == 0) if_addr = $urandom;
      if (exp_da) dm_req = 1'b0;
      else if (!dm_req && cyc < 2800 && $urandom_range(2) == 0) begin
        dm_req = 1'b1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
      end else if (dm_req && busy && bk == 2 && $urandom_range(3) == 0) begin
        dm_we = ~dm_we; dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom);
      end

      ack_drv = 0;
      if (busy) begin
        bcyc++;
        if (bcyc >= 4 || $urandom_range(2) == 0) begin
          r_data = $urandom; mem_rdata = r_data; mem_ack = 1'b1; ack_drv = 1;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        mem_ack = ($urandom_range(7) == 0); mem_rdata = $urandom;
      end

      if (port_free && (if_req || dm_req)) begin
        if (dm_req && !(if_req && streak_m == MAX_D)) begin
          gk = 2; g_we = dm_we; g_addr = dm_addr; g_wdata = dm_wdata; g_be = dm_be;
          streak_m = if_req ? ((streak_m < MAX_D) ? streak_m + 1 : streak_m) : 0;
        end else begin
          gk = 1; g_we = 1'b0; g_addr = if_addr; g_wdata = '0; g_be = 4'hF;
          streak_m = 0;
        end
        port_free = 0;
      end
      if (cyc >= 2800 && !busy && !if_req && !dm_req && port_free && gk == 0) break;
    end
    mem_ack = 1'b0;
    checks++; if (cyc >= 3000) begin errors++; $display("FAIL rnd_drain got %0d cycles want < 3000", cyc); end
  endtask

  initial begin
    test_reset;
    test_if_read;
    test_dm_write;
    test_priority;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
